sr_dr_csr_regs: RTL

- Generalised console switch/display register block on the iopage. It presents debounced front-panel switches at the switch-register address and a writable display register at the same address.
- Adds a control/status register (CSR) with a sticky switch-change flag and a level interrupt request.
- Sits on the iopage bus beside the other *_regs blocks. Its `decode` and `data_out` feed the iopage read mux.

---
 rtl/sr_dr_csr_regs_pkg.sv | 16 +
 rtl/sr_dr_csr_regs_if.sv | 23 ++
 rtl/sr_dr_csr_regs_debounce.sv | 64 ++++++
 rtl/sr_dr_csr_regs.sv | 112 +++++++++++
 4 files changed

// File: rtl/sr_dr_csr_regs_pkg.sv
// Shared constants for the console switch/display register block:
// default iopage offsets, CSR bit positions and the debounce saturation helper.
package sr_pkg;

  localparam logic [12:0] SR_ADDR_DEF  = 13'o17570;
  localparam logic [12:0] CSR_ADDR_DEF = 13'o17572;

  localparam int CSR_CHG = 15;
  localparam int CSR_IE  = 6;

  // Saturation value of a debounce counter that is 'bits' wide.
  function automatic logic [63:0] db_all_ones(input int bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

endpackage

// File: rtl/sr_dr_csr_regs_if.sv
// Iopage bus slice seen by the switch/display registers: address, strobes,
// write data, and the read data / decode returned to the iopage read mux.
interface sr_dr_csr_regs_if;

  logic [12:0] iopage_addr;
  logic [15:0] data_in;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic [15:0] data_out;
  logic        decode;

  modport master (
    output iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    input  data_out, decode
  );

  modport slave (
    input  iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    output data_out, decode
  );

endinterface

// File: rtl/sr_dr_csr_regs_debounce.sv
// Switch synchroniser plus whole-word debouncer: a word is accepted only after
// it has been stable for 2^DB_BITS clocks; chg_pulse marks the accepting edge.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raw,
  output logic [15:0] db,
  output logic        chg_pulse
);

  localparam logic [DB_BITS-1:0] CNT_MAX = DB_BITS'(db_all_ones(DB_BITS));

  logic [15:0]        sync_r [SYNC_STAGES];
  logic [15:0]        cand_r;
  logic [DB_BITS-1:0] cnt_r;
  logic [15:0]        sw_db_r;
  logic [15:0]        s_s;

  assign s_s = sync_r[SYNC_STAGES-1];
  assign db  = sw_db_r;

  // Accept the candidate on the edge where its qualification time has elapsed.
  always_comb begin
    chg_pulse = 1'b0;
    if ((s_s == cand_r) && (cnt_r == CNT_MAX) && (cand_r != sw_db_r)) begin
      chg_pulse = 1'b1;
    end else begin
      chg_pulse = 1'b0;
    end
  end

  // Synchroniser chain, candidate tracking and saturating stability counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 16'h0000;
      end
      cand_r  <= 16'h0000;
      cnt_r   <= '0;
      sw_db_r <= 16'h0000;
    end else begin
      sync_r[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      if (s_s != cand_r) begin
        cand_r <= s_s;
        cnt_r  <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + DB_BITS'(1);
      end else if (chg_pulse) begin
        sw_db_r <= cand_r;
      end else begin
        sw_db_r <= sw_db_r;
      end
    end
  end

endmodule

// File: rtl/sr_dr_csr_regs.sv
// Console switch register (read) / display register (write) at SR_ADDR, plus a
// CSR at CSR_ADDR with a sticky switch-change flag and a level interrupt.
module sr_dr_csr_regs
  import sr_pkg::*;
#(
  parameter logic [12:0] SR_ADDR     = SR_ADDR_DEF,
  parameter logic [12:0] CSR_ADDR    = CSR_ADDR_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int          DB_BITS     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sr_dr_csr_regs_if.slave      bus,
  input  logic [15:0]          switches,
  output logic [15:0]          display,
  output logic                 irq
);

  logic [15:0] sw_db_s;
  logic        chg_pulse_s;
  logic        sr_hit_s;
  logic        csr_hit_s;
  logic        lo_we_s;
  logic        hi_we_s;
  logic        sr_wr_s;
  logic        csr_wr_s;
  logic [15:0] display_r;
  logic        chg_r;
  logic        ie_r;
  logic        unused_s;

  sr_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_BITS     (DB_BITS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw       (switches),
    .db        (sw_db_s),
    .chg_pulse (chg_pulse_s)
  );

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_s = bus.iopage_rd;

  assign sr_hit_s   = (bus.iopage_addr[12:1] == SR_ADDR[12:1]);
  assign csr_hit_s  = (bus.iopage_addr[12:1] == CSR_ADDR[12:1]);
  assign bus.decode = sr_hit_s | csr_hit_s;

  assign lo_we_s  = !bus.iopage_byte_op || !bus.iopage_addr[0];
  assign hi_we_s  = !bus.iopage_byte_op ||  bus.iopage_addr[0];
  assign sr_wr_s  = bus.iopage_wr && sr_hit_s;
  assign csr_wr_s = bus.iopage_wr && csr_hit_s;

  assign display = display_r;
  assign irq     = chg_r & ie_r;

  // Read mux: switch word, CSR image, or zero when not addressed.
  always_comb begin
    bus.data_out = 16'h0000;
    if (sr_hit_s) begin
      bus.data_out = sw_db_s;
    end else if (csr_hit_s) begin
      bus.data_out = {chg_r, 8'h00, ie_r, 6'b000000};
    end else begin
      bus.data_out = 16'h0000;
    end
  end

  // Display register with byte-lane writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      display_r <= 16'h0000;
    end else if (sr_wr_s) begin
      if (lo_we_s) begin
        display_r[7:0] <= bus.data_in[7:0];
      end else begin
        display_r[7:0] <= display_r[7:0];
      end
      if (hi_we_s) begin
        display_r[15:8] <= bus.data_in[15:8];
      end else begin
        display_r[15:8] <= display_r[15:8];
      end
    end else begin
      display_r <= display_r;
    end
  end

  // CSR: IE is plain read/write; CHG is set by the debouncer (which beats a
  // simultaneous clear) and cleared by writing 1 to its bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chg_r <= 1'b0;
      ie_r  <= 1'b0;
    end else begin
      if (chg_pulse_s) begin
        chg_r <= 1'b1;
      end else if (csr_wr_s && hi_we_s && bus.data_in[CSR_CHG]) begin
        chg_r <= 1'b0;
      end else begin
        chg_r <= chg_r;
      end
      if (csr_wr_s && lo_we_s) begin
        ie_r <= bus.data_in[CSR_IE];
      end else begin
        ie_r <= ie_r;
      end
    end
  end

endmodule
